// File: rtl/ram_n_clr.sv
`default_nettype none
// ============================================================================
//  Module   : ram_n_clr
//  Purpose  : 2^ADDR_W x WIDTH single-port word memory with a built-in
//             zero-fill sequencer. After reset or on a clear request every
//             word is swept to zero, one word per clock, while busy is high.
//
//  Ports    : clk      - single clock, all state updates on the rising edge
//             reset    - synchronous active-high, (re)starts the clear sweep
//             in       - write data
//             address  - read/write word address
//             load     - write enable for mem[address]
//             clear    - single-cycle request to zero the whole memory
//             out      - read data (forced to 0 while busy)
//             busy     - high while the clear sweep is running
//
//  Config   : RAM_N_CLR_BYPASS_EN
//               defined   -> write-first read: a pending load shows `in` on
//                            `out` combinationally in the same cycle.
//               undefined -> read-before-write: `out` shows the stored word
//                            until the write edge.
//
//  Revision : 1.0 - initial release
// ============================================================================
module ram_n_clr #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Single write port shared between the sweep and normal loads.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    // A user load is only accepted in IDLE and loses to a same-cycle clear.
    logic              user_write;

    assign busy       = (state == ST_SWEEP);
    assign user_write = !busy && load && !clear;

    // ------------------------------------------------------------------------
    // Write-port steering. The reset edge itself writes nothing: it only
    // arms the sweep, so the first zero lands on the first edge with
    // reset low.
    // ------------------------------------------------------------------------
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address;
        wr_data = in;
        if (!reset) begin
            if (busy) begin
                wr_en   = 1'b1;
                wr_addr = ptr;
                wr_data = '0;
            end else if (user_write) begin
                wr_en   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sweep sequencer: IDLE <-> SWEEP, ptr walks 0..DEPTH-1 exactly once.
    // Reset outranks everything, including a sweep already in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SWEEP;
            ptr   <= '0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    if (ptr == LAST_PTR) begin
                        state <= ST_IDLE;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    if (clear) begin
                        state <= ST_SWEEP;
                        ptr   <= '0;
                    end
                end
            endcase
        end
    end

    // Storage array: no reset, the sweep is what gives it a defined value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Combinational read. While sweeping, the array is partly stale, so the
    // output is held at zero rather than exposing half-cleared contents.
    // ------------------------------------------------------------------------
`ifdef RAM_N_CLR_BYPASS_EN
    always_comb begin
        if (busy) begin
            out = '0;
        end else if (user_write) begin
            out = in;
        end else begin
            out = mem[address];
        end
    end
`else
    always_comb begin
        if (busy) begin
            out = '0;
        end else begin
            out = mem[address];
        end
    end
`endif

endmodule
`default_nettype wire
